// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU results and extended load returns onto the
// single register-file write port. Loads wait in a small in-order queue.
module wb_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int REG_SEL_BITS = 5,
    parameter int LQ_DEPTH     = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          alu_valid,
    input  logic [REG_SEL_BITS-1:0]       alu_rd,
    input  logic [DATA_WIDTH-1:0]         alu_data,
    output logic                          alu_ready,
    input  logic                          ld_valid,
    input  logic [REG_SEL_BITS-1:0]       ld_rd,
    input  logic [DATA_WIDTH-1:0]         ld_data,
    input  logic [1:0]                    ld_size,
    input  logic                          ld_unsigned,
    input  logic [1:0]                    ld_offset,
    output logic                          ld_ready,
    output logic                          wb_wEn,
    output logic [REG_SEL_BITS-1:0]       wb_write_sel,
    output logic [DATA_WIDTH-1:0]         wb_write_data,
    output logic [$clog2(LQ_DEPTH):0]     lq_count
);
    localparam int AW = $clog2(LQ_DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [REG_SEL_BITS-1:0] rd;
        logic [DATA_WIDTH-1:0]   data;
    } lq_entry_t;

    lq_entry_t               mem [LQ_DEPTH];
    lq_entry_t               head;
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic                    full, empty, push, pop, alu_win, win;
    logic [DATA_WIDTH-1:0]   byte_sh, half_sh, ld_ext;
    logic [REG_SEL_BITS-1:0] win_rd;
    logic [DATA_WIDTH-1:0]   win_data;

    assign full      = (lq_count == CW'(LQ_DEPTH));
    assign empty     = (lq_count == '0);
    // Readiness comes from registered occupancy only; a same-cycle pop never opens a slot.
    assign alu_ready = reset && !full;
    assign ld_ready  = reset && !full;
    assign head      = mem[rd_ptr];

    assign pop     = reset && !empty && (full || !alu_valid);
    assign alu_win = alu_valid && alu_ready && !pop;
    assign push    = ld_valid && ld_ready;

    assign win      = pop || alu_win;
    assign win_rd   = pop ? head.rd   : alu_rd;
    assign win_data = pop ? head.data : alu_data;

    assign byte_sh = ld_data >> {ld_offset, 3'b000};
    assign half_sh = ld_data >> {ld_offset[1], 4'b0000};

    always_comb begin
        ld_ext = ld_data;
        case (ld_size)
            2'b00:   ld_ext = {{(DATA_WIDTH-8){!ld_unsigned && byte_sh[7]}}, byte_sh[7:0]};
            2'b01:   ld_ext = {{(DATA_WIDTH-16){!ld_unsigned && half_sh[15]}}, half_sh[15:0]};
            default: ld_ext = ld_data;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= '{rd: ld_rd, data: ld_ext};
    end

    // Pointers wrap naturally since LQ_DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            lq_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            lq_count <= lq_count + CW'(push) - CW'(pop);
        end
    end

    // A winner targeting r0 is consumed but suppressed; sel/data hold when idle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wb_wEn        <= 1'b0;
            wb_write_sel  <= '0;
            wb_write_data <= '0;
        end else begin
            wb_wEn <= win && (win_rd != '0);
            if (win && (win_rd != '0)) begin
                wb_write_sel  <= win_rd;
                wb_write_data <= win_data;
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_wb_arbiter;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int LQD = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          alu_valid = 1'b0;
    logic [RW-1:0] alu_rd = '0;
    logic [DW-1:0] alu_data = '0;
    logic          alu_ready;
    logic          ld_valid = 1'b0;
    logic [RW-1:0] ld_rd = '0;
    logic [DW-1:0] ld_data = '0;
    logic [1:0]    ld_size = '0;
    logic          ld_unsigned = 1'b0;
    logic [1:0]    ld_offset = '0;
    logic          ld_ready;
    logic          wb_wEn;
    logic [RW-1:0] wb_write_sel;
    logic [DW-1:0] wb_write_data;
    logic [1:0]    lq_count;

    wb_arbiter #(.DATA_WIDTH(DW), .REG_SEL_BITS(RW), .LQ_DEPTH(LQD)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_size(ld_size),
        .ld_unsigned(ld_unsigned), .ld_offset(ld_offset), .ld_ready(ld_ready),
        .wb_wEn(wb_wEn), .wb_write_sel(wb_write_sel), .wb_write_data(wb_write_data),
        .lq_count(lq_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           mq[$];
    logic          m_wen = 1'b0;
    logic [RW-1:0] m_sel = '0;
    logic [DW-1:0] m_data = '0;
    logic          m_rdy = 1'b0;
    logic          obs_alu_rdy, obs_ld_rdy;

    function automatic logic [DW-1:0] extend(logic [DW-1:0] d, logic [1:0] sz, logic uns, logic [1:0] off);
        logic [7:0]         b;
        logic [15:0]        h;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        int                 v;
        b = d[8*off +: 8];
        h = d[16*off[1] +: 16];
        case (sz)
            2'b00: begin
                if (uns) return DW'(b);
                sb = b; v = sb; return v;
            end
            2'b01: begin
                if (uns) return DW'(h);
                sh = h; v = sh; return v;
            end
            default: return d;
        endcase
    endfunction

    // Reference: queue head has priority when full or ALU idle; r0 writes vanish.
    task automatic model_step();
        wr_t  w;
        logic have;
        if (!reset) begin
            m_rdy = 1'b0; mq.delete();
            m_wen = 1'b0; m_sel = '0; m_data = '0;
            return;
        end
        m_rdy = (mq.size() < LQD);
        have = 1'b0;
        if (mq.size() > 0 && (mq.size() == LQD || !alu_valid)) begin
            w = mq.pop_front(); have = 1'b1;
        end else if (alu_valid) begin
            w.rd = alu_rd; w.data = alu_data; have = 1'b1;
        end
        m_wen = have && (w.rd != 0);
        if (m_wen) begin m_sel = w.rd; m_data = w.data; end
        if (ld_valid && m_rdy)
            mq.push_back('{rd: ld_rd, data: extend(ld_data, ld_size, ld_unsigned, ld_offset)});
    endtask

    // Inputs are driven after posedge; readies sampled mid-cycle; outputs sampled #1 after posedge.
    task automatic cycle();
        @(negedge clock);
        #1;
        obs_alu_rdy = alu_ready;
        obs_ld_rdy  = ld_ready;
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; alu_valid = 1'b1; alu_rd = 5'd3; ld_valid = 1'b1; ld_rd = 5'd4;
        repeat (3) begin
            cycle();
            checks++; if (obs_alu_rdy !== 1'b0) begin failures++; $display("FAIL reset_alu_ready got=%b exp=0", obs_alu_rdy); end
            checks++; if (obs_ld_rdy !== 1'b0) begin failures++; $display("FAIL reset_ld_ready got=%b exp=0", obs_ld_rdy); end
            checks++; if (wb_wEn !== 1'b0) begin failures++; $display("FAIL reset_wen got=%b exp=0", wb_wEn); end
            checks++; if (lq_count !== 2'd0) begin failures++; $display("FAIL reset_lq_count got=%0d exp=0", lq_count); end
            checks++; if (wb_write_sel !== '0 || wb_write_data !== '0) begin failures++; $display("FAIL reset_sel_data got=%0d/%h exp=0/0", wb_write_sel, wb_write_data); end
        end
        reset = 1'b1; alu_valid = 1'b0; ld_valid = 1'b0;
        cycle();
        checks++; if (obs_alu_rdy !== 1'b1 || obs_ld_rdy !== 1'b1) begin failures++; $display("FAIL release_ready got=%b%b exp=11", obs_alu_rdy, obs_ld_rdy); end
    endtask

    task automatic test_alu();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234_5678;
        cycle();
        alu_valid = 1'b0;
        checks++; if (wb_wEn !== 1'b1 || wb_write_sel !== 5'd5 || wb_write_data !== 32'h1234_5678) begin
            failures++; $display("FAIL alu_write got=%b/%0d/%h exp=1/5/12345678", wb_wEn, wb_write_sel, wb_write_data); end
        cycle();
        checks++; if (wb_wEn !== 1'b0) begin failures++; $display("FAIL alu_one_cycle got=%b exp=0", wb_wEn); end
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD_BEEF;
        cycle();
        alu_valid = 1'b0;
        checks++; if (obs_alu_rdy !== 1'b1) begin failures++; $display("FAIL alu_r0_ready got=%b exp=1", obs_alu_rdy); end
        checks++; if (wb_wEn !== 1'b0 || wb_write_sel !== 5'd5 || wb_write_data !== 32'h1234_5678) begin
            failures++; $display("FAIL alu_r0_hold got=%b/%0d/%h exp=0/5/12345678", wb_wEn, wb_write_sel, wb_write_data); end
    endtask

    task automatic test_load_ext();
        logic [1:0]  sz  [4] = '{2'd0, 2'd0, 2'd1, 2'd2};
        logic        uns [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0]  off [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [31:0] exp [4] = '{32'hFFFF_FF82, 32'h0000_007F, 32'hFFFF_80F1, 32'h80F1_7F82};
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1; ld_rd = RW'(10 + i); ld_data = 32'h80F1_7F82;
            ld_size = sz[i]; ld_unsigned = uns[i]; ld_offset = off[i];
            cycle();
            ld_valid = 1'b0;
            checks++; if (wb_wEn !== 1'b0 || lq_count !== 2'd1) begin
                failures++; $display("FAIL ldext%0d_n1 got wen=%b cnt=%0d exp wen=0 cnt=1", i, wb_wEn, lq_count); end
            cycle();
            checks++; if (wb_wEn !== 1'b1 || wb_write_sel !== RW'(10 + i) || wb_write_data !== exp[i]) begin
                failures++; $display("FAIL ldext%0d_n2 got=%b/%0d/%h exp=1/%0d/%h", i, wb_wEn, wb_write_sel, wb_write_data, 10 + i, exp[i]); end
        end
    endtask

    task automatic test_contention();
        int   a_i = 1, l_i = 0, max_cnt = 0;
        logic saw_stall = 1'b0;
        int   log[$];
        int   exp_seq [11] = '{1, 2, 20, 3, 21, 4, 5, 6, 7, 8, 22};
        for (int c = 0; c < 20; c++) begin
            alu_valid = (a_i <= 8); alu_rd = RW'(a_i); alu_data = 32'(100 + a_i);
            ld_valid = (l_i < 3); ld_rd = RW'(20 + l_i); ld_data = $urandom; ld_size = 2'd2;
            cycle();
            if (alu_valid && obs_alu_rdy) a_i++;
            if (ld_valid && obs_ld_rdy) l_i++;
            if (!obs_alu_rdy && !obs_ld_rdy) saw_stall = 1'b1;
            if (int'(lq_count) > max_cnt) max_cnt = int'(lq_count);
            if (wb_wEn === 1'b1) log.push_back(int'(wb_write_sel));
            checks++; if (wb_wEn !== m_wen || (m_wen && wb_write_sel !== m_sel)) begin
                failures++; $display("FAIL contention_c%0d got=%b/%0d exp=%b/%0d", c, wb_wEn, wb_write_sel, m_wen, m_sel); end
        end
        alu_valid = 1'b0; ld_valid = 1'b0;
        checks++; if (max_cnt != 2 || !saw_stall) begin failures++; $display("FAIL contention_full got max=%0d stall=%b exp 2/1", max_cnt, saw_stall); end
        checks++; if (log.size() != 11) begin failures++; $display("FAIL contention_count got=%0d exp=11", log.size()); end
        else for (int k = 0; k < 11; k++)
            if (log[k] != exp_seq[k]) begin failures++; $display("FAIL contention_order idx=%0d got=%0d exp=%0d", k, log[k], exp_seq[k]); end
    endtask

    task automatic test_wrap();
        wr_t  sb[$];
        wr_t  e;
        int   accepted = 0, cyc = 0;
        logic prev_low = 1'b0;
        while ((accepted < 34 || sb.size() != 0 || lq_count != 0) && cyc < 300) begin
            alu_valid = 1'b1; alu_rd = RW'($urandom_range(1, 15)); alu_data = $urandom;
            ld_valid = (accepted < 34); ld_rd = RW'($urandom_range(16, 31)); ld_data = $urandom;
            ld_size = 2'($urandom); ld_unsigned = 1'($urandom); ld_offset = 2'($urandom);
            if (accepted >= 34) alu_valid = 1'b0;
            cycle();
            cyc++;
            if (prev_low) begin
                checks++; if (obs_ld_rdy !== 1'b1) begin failures++; $display("FAIL wrap_ready_return cyc=%0d got=%b exp=1", cyc, obs_ld_rdy); end
            end
            prev_low = ld_valid && !obs_ld_rdy;
            if (ld_valid && obs_ld_rdy) begin
                sb.push_back('{rd: ld_rd, data: extend(ld_data, ld_size, ld_unsigned, ld_offset)});
                accepted++;
            end
            if (wb_wEn === 1'b1 && wb_write_sel >= 16) begin
                checks++;
                if (sb.size() == 0) begin failures++; $display("FAIL wrap_dup got=%0d/%h exp none", wb_write_sel, wb_write_data); end
                else begin
                    e = sb.pop_front();
                    if (wb_write_sel !== e.rd || wb_write_data !== e.data) begin
                        failures++; $display("FAIL wrap_order got=%0d/%h exp=%0d/%h", wb_write_sel, wb_write_data, e.rd, e.data); end
                end
            end
        end
        alu_valid = 1'b0; ld_valid = 1'b0;
        checks++; if (accepted != 34 || sb.size() != 0) begin failures++; $display("FAIL wrap_drain got acc=%0d left=%0d exp 34/0", accepted, sb.size()); end
    endtask

    task automatic test_mid_reset();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33; ld_valid = 1'b1; ld_rd = 5'd9; ld_size = 2'd2; ld_data = 32'h99;
        cycle();
        alu_rd = 5'd4; ld_rd = 5'd10;
        cycle();
        checks++; if (lq_count !== 2'd2) begin failures++; $display("FAIL midrst_fill got=%0d exp=2", lq_count); end
        reset = 1'b0; alu_valid = 1'b0; ld_valid = 1'b0;
        cycle();
        checks++; if (lq_count !== 2'd0 || wb_wEn !== 1'b0) begin failures++; $display("FAIL midrst_clear got cnt=%0d wen=%b exp 0/0", lq_count, wb_wEn); end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (wb_wEn !== 1'b0) begin failures++; $display("FAIL midrst_nowrite%0d got=%b/%0d exp=0", i, wb_wEn, wb_write_sel); end
        end
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0000_A5A5;
        cycle();
        alu_valid = 1'b0;
        checks++; if (wb_wEn !== 1'b1 || wb_write_sel !== 5'd7 || wb_write_data !== 32'h0000_A5A5) begin
            failures++; $display("FAIL midrst_alu got=%b/%0d/%h exp=1/7/0000a5a5", wb_wEn, wb_write_sel, wb_write_data); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 49) != 0);
            alu_valid = 1'($urandom); alu_rd = RW'($urandom_range(0, 31)); alu_data = $urandom;
            ld_valid = 1'($urandom); ld_rd = RW'($urandom_range(0, 31)); ld_data = $urandom;
            ld_size = 2'($urandom); ld_unsigned = 1'($urandom); ld_offset = 2'($urandom);
            cycle();
            checks++; if (obs_alu_rdy !== m_rdy || obs_ld_rdy !== m_rdy) begin
                failures++; $display("FAIL rand_ready c=%0d got=%b%b exp=%b", c, obs_alu_rdy, obs_ld_rdy, m_rdy); end
            checks++; if (wb_wEn !== m_wen || wb_write_sel !== m_sel || wb_write_data !== m_data) begin
                failures++; $display("FAIL rand_write c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, wb_wEn, wb_write_sel, wb_write_data, m_wen, m_sel, m_data); end
            checks++; if (lq_count !== 2'(mq.size())) begin
                failures++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, lq_count, mq.size()); end
        end
        reset = 1'b1; alu_valid = 1'b0; ld_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_ext();
        test_contention();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
